// File: rtl/softmax_argmax.sv
// Streaming argmax over consecutive groups of N_CLASS bf16 elements; emits winner index/value per group.
// Optional build macro SOFTMAX_ARGMAX_NAN_FLAG_EN adds result_nan (any NaN seen in the reported vector).
module softmax_argmax #(
    parameter int N_CLASS = 10,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_tvalid,
    input  logic [31:0]      a_tdata,
    output logic             result_tvalid,
    output logic [IDX_W-1:0] result_idx,
    output logic [31:0]      result_tdata,
`ifdef SOFTMAX_ARGMAX_NAN_FLAG_EN
    output logic             result_nan,
`endif
    output logic [CNT_W-1:0] vec_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

    typedef enum logic {
        S_IDLE,
        S_ACC
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [15:0]      best_q, best_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             best_nan_q, best_nan_d;

    logic             res_valid_q, res_valid_d;
    logic [IDX_W-1:0] res_idx_q, res_idx_d;
    logic [15:0]      res_val_q, res_val_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;

`ifdef SOFTMAX_ARGMAX_NAN_FLAG_EN
    logic             nan_seen_q, nan_seen_d;
    logic             res_nan_q, res_nan_d;
`endif

    logic [15:0] elem;
    logic        elem_nan;
    logic        cand_wins;
    logic        unused_lo;

    assign elem      = a_tdata[31:16];
    assign unused_lo = ^a_tdata[15:0];

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
    endfunction

    // Monotone unsigned key: -0 folded onto +0, negatives inverted, positives offset.
    function automatic logic [15:0] order_key(input logic [15:0] x);
        logic [15:0] c;
        c = (x == 16'h8000) ? 16'h0000 : x;
        return c[15] ? ~c : (c ^ 16'h8000);
    endfunction

    assign elem_nan  = is_nan(elem);
    // A NaN best (only possible from element 0) yields to any real number.
    assign cand_wins = !elem_nan && (best_nan_q || (order_key(elem) > order_key(best_q)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        best_nan_d  = best_nan_q;
        res_valid_d = 1'b0;
        res_idx_d   = res_idx_q;
        res_val_d   = res_val_q;
        vec_cnt_d   = vec_cnt_q;
`ifdef SOFTMAX_ARGMAX_NAN_FLAG_EN
        nan_seen_d  = nan_seen_q;
        res_nan_d   = res_nan_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (a_tvalid) begin
                    best_d     = elem;
                    best_idx_d = '0;
                    best_nan_d = elem_nan;
                    cnt_d      = IDX_W'(1);
                    state_d    = S_ACC;
`ifdef SOFTMAX_ARGMAX_NAN_FLAG_EN
                    nan_seen_d = elem_nan;
`endif
                end
            end
            S_ACC: begin
                if (a_tvalid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cand_wins) begin
                        best_d     = elem;
                        best_idx_d = cnt_q;
                        best_nan_d = 1'b0;
                    end
`ifdef SOFTMAX_ARGMAX_NAN_FLAG_EN
                    nan_seen_d = nan_seen_q | elem_nan;
`endif
                    if (cnt_q == LAST_IDX) begin
                        res_valid_d = 1'b1;
                        res_idx_d   = cand_wins ? cnt_q : best_idx_q;
                        res_val_d   = cand_wins ? elem : best_q;
                        vec_cnt_d   = vec_cnt_q + 1'b1;
                        cnt_d       = '0;
                        state_d     = S_IDLE;
`ifdef SOFTMAX_ARGMAX_NAN_FLAG_EN
                        res_nan_d   = nan_seen_q | elem_nan;
`endif
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            best_nan_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_val_q   <= '0;
            vec_cnt_q   <= '0;
`ifdef SOFTMAX_ARGMAX_NAN_FLAG_EN
            nan_seen_q  <= 1'b0;
            res_nan_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            best_nan_q  <= best_nan_d;
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
            res_val_q   <= res_val_d;
            vec_cnt_q   <= vec_cnt_d;
`ifdef SOFTMAX_ARGMAX_NAN_FLAG_EN
            nan_seen_q  <= nan_seen_d;
            res_nan_q   <= res_nan_d;
`endif
        end
    end

    assign result_tvalid = res_valid_q;
    assign result_idx    = res_idx_q;
    assign result_tdata  = {res_val_q, 16'h0000};
    assign vec_count     = vec_cnt_q;
`ifdef SOFTMAX_ARGMAX_NAN_FLAG_EN
    assign result_nan    = res_nan_q;
`endif

endmodule

// File: tb/tb_softmax_argmax.sv
// Scoreboard bench for softmax_argmax: real-valued argmax reference model, decoupled negedge monitor.
module tb_softmax_argmax;
    localparam int N_CLASS = 10;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 16;

    typedef logic [15:0] vec_t [N_CLASS];
    typedef struct {
        int unsigned idx;
        logic [15:0] val;
        logic        nan;
        int unsigned count;
        int unsigned cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_tvalid;
    logic [31:0]      a_tdata;
    logic             result_tvalid;
    logic [IDX_W-1:0] result_idx;
    logic [31:0]      result_tdata;
    logic [CNT_W-1:0] vec_count;
`ifdef SOFTMAX_ARGMAX_NAN_FLAG_EN
    logic             result_nan;
`endif

    softmax_argmax #(.N_CLASS(N_CLASS), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_tvalid     (a_tvalid),
        .a_tdata      (a_tdata),
        .result_tvalid(result_tvalid),
        .result_idx   (result_idx),
        .result_tdata (result_tdata),
`ifdef SOFTMAX_ARGMAX_NAN_FLAG_EN
        .result_nan   (result_nan),
`endif
        .vec_count    (vec_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb_q[$];
    int unsigned model_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic bit bf_is_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 0);
    endfunction

    function automatic real bf_val(input logic [15:0] x);
        int  e;
        int  m;
        real mag;
        e = int'(x[14:7]);
        m = int'(x[6:0]);
        if (e == 0)        mag = (m / 128.0) * (2.0 ** (-126));
        else if (e == 255) mag = 1.0e300;
        else               mag = (1.0 + m / 128.0) * (2.0 ** (e - 127));
        return x[15] ? -mag : mag;
    endfunction

    // First index holding the largest non-NaN value; 0 if every element is NaN.
    function automatic exp_t model(input vec_t v);
        exp_t r;
        int   best;
        best  = -1;
        r.nan = 1'b0;
        for (int i = 0; i < N_CLASS; i++) begin
            if (bf_is_nan(v[i])) r.nan = 1'b1;
            else if (best < 0 || bf_val(v[i]) > bf_val(v[best])) best = i;
        end
        if (best < 0) best = 0;
        r.idx   = best;
        r.val   = v[best];
        r.count = 0;
        r.cyc   = 0;
        return r;
    endfunction

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            a_tvalid = 1'b0;
            a_tdata  = $urandom;
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_elem(input logic [15:0] x);
        a_tvalid = 1'b1;
        a_tdata  = {x, 16'($urandom)};
        @(posedge clk); #1;
        a_tvalid = 1'b0;
    endtask

    task automatic send_vec(input vec_t v, input int gap_at, input int gap_len, input bit rnd_gap);
        exp_t e;
        for (int i = 0; i < N_CLASS; i++) begin
            if (i == gap_at) idle(gap_len);
            if (rnd_gap && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            drive_elem(v[i]);
        end
        model_count = (model_count + 1) % (1 << CNT_W);
        e       = model(v);
        e.count = model_count;
        e.cyc   = cyc;
        sb_q.push_back(e);
        $display("vec %0d: expect idx=%0d val=0x%04h nan=%0d at cycle %0d",
                 model_count, e.idx, e.val, e.nan, e.cyc);
    endtask

    function automatic vec_t fill(input logic [15:0] base, input int pos, input logic [15:0] peak);
        vec_t v;
        for (int i = 0; i < N_CLASS; i++) v[i] = base;
        v[pos] = peak;
        return v;
    endfunction

    function automatic logic [15:0] rand_elem();
        logic [15:0] x;
        case ($urandom_range(0, 11))
            0:       x = {1'($urandom), 8'hFF, 7'($urandom_range(1, 127))};
            1:       x = {1'($urandom), 8'hFF, 7'h00};
            2:       x = {1'($urandom), 15'h0000};
            3:       x = {1'($urandom), 8'h00, 7'($urandom_range(1, 127))};
            default: x = {1'($urandom), 8'($urandom_range(110, 135)), 7'($urandom)};
        endcase
        return x;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && result_tvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 64'(result_idx), 64'hFFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                check("result_idx", 64'(result_idx), 64'(e.idx));
                check("result_tdata", 64'(result_tdata), {32'h0, e.val, 16'h0000});
                check("vec_count", 64'(vec_count), 64'(e.count));
`ifdef SOFTMAX_ARGMAX_NAN_FLAG_EN
                check("result_nan", 64'(result_nan), 64'(e.nan));
`endif
                $display("result: idx=%0d tdata=0x%08h vec_count=%0d", result_idx, result_tdata, vec_count);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 64'(result_tvalid), 64'h0);
        check({tag, "_idx"}, 64'(result_idx), 64'h0);
        check({tag, "_tdata"}, 64'(result_tdata), 64'h0);
        check({tag, "_vec_count"}, 64'(vec_count), 64'h0);
`ifdef SOFTMAX_ARGMAX_NAN_FLAG_EN
        check({tag, "_nan"}, 64'(result_nan), 64'h0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst_n    = 1'b0;
        a_tvalid = 1'b0;
        a_tdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // single peak, contiguous
        v = fill(16'h3D4C, 7, 16'h3F00);
        send_vec(v, -1, 0, 1'b0);
        idle(3);

        // tie between idx 2 and 5
        v = fill(16'h3C00, 2, 16'h3E80);
        v[5] = 16'h3E80;
        send_vec(v, -1, 0, 1'b0);
        idle(2);

        // three back-to-back vectors
        v = fill(16'h3C00, 0, 16'h3F00); send_vec(v, -1, 0, 1'b0);
        v = fill(16'h3C00, 9, 16'h3F00); send_vec(v, -1, 0, 1'b0);
        v = fill(16'h3C00, 4, 16'h3F00); send_vec(v, -1, 0, 1'b0);
        idle(3);

        // gap of 3 cycles between elements 4 and 5
        v = fill(16'h3D4C, 7, 16'h3F00);
        send_vec(v, 5, 3, 1'b0);
        idle(3);

        // reset after element 6 aborts the vector
        v = fill(16'h3C00, 3, 16'h3F00);
        for (int i = 0; i < 7; i++) drive_elem(v[i]);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        model_count = 0;
        v = fill(16'h3C00, 1, 16'h3F80);
        send_vec(v, -1, 0, 1'b0);
        idle(3);

        // element 0 NaN superseded by first real value
        v = fill(16'h3C00, 3, 16'h3F80);
        v[0] = 16'h7FC0;
        send_vec(v, -1, 0, 1'b0);

        // -0 and +0 tie, all others negative
        v = fill(16'hBF80, 0, 16'h8000);
        v[3] = 16'h0000;
        send_vec(v, -1, 0, 1'b0);

        // all-NaN vector
        v = fill(16'hFFC0, 0, 16'h7FC1);
        send_vec(v, -1, 0, 1'b0);

        // infinities as extremes
        v = fill(16'hFF80, 6, 16'h7F80);
        v[8] = 16'h7F80;
        send_vec(v, -1, 0, 1'b0);
        idle(2);

        // randomized vectors with ties and random gaps
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N_CLASS; i++) begin
                if (i > 0 && $urandom_range(0, 5) == 0) v[i] = v[$urandom_range(0, i - 1)];
                else v[i] = rand_elem();
            end
            send_vec(v, -1, 0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end

        idle(5);
        check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        check("final_vec_count", 64'(vec_count), 64'(model_count));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
